// File: rtl/ex_pkg.sv
// Shared execute-stage definitions.
//  - ALUControl op codes, including the iterative multiply/divide ops
//  - state encoding of the multiply/divide unit
//  - is_md_op(): true for the ops the multiply/divide unit executes
package ex_pkg;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_NOR  = 5'b01001;
    localparam logic [4:0] ALU_MUL  = 5'b00100;
    localparam logic [4:0] ALU_MULU = 5'b10101;
    localparam logic [4:0] ALU_DIV  = 5'b00011;
    localparam logic [4:0] ALU_DIVU = 5'b10100;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_RUN   = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit connection.
//  master: execute stage (drives op, operands, flush; sees stall/done/HI/LO)
//  slave : ex_muldiv_unit
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic [4:0]       ALUControlE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             FlushE;
    logic             StallMD;
    logic             DoneE;
    logic [WIDTH-1:0] HiE;
    logic [WIDTH-1:0] LoE;

    modport master (
        output StartE, ALUControlE, SrcAE, SrcBE, FlushE,
        input  StallMD, DoneE, HiE, LoE
    );

    modport slave (
        input  StartE, ALUControlE, SrcAE, SrcBE, FlushE,
        output StallMD, DoneE, HiE, LoE
    );
endinterface

// File: rtl/ex_muldiv_unit_step.sv
// muldiv_step: one combinational radix-2 iteration on a {hi,lo} pair.
//  is_div=0: shift-add multiply. lo holds the remaining multiplier bits,
//            hi the partial product; opnd is the multiplicand.
//  is_div=1: restoring divide. hi is the partial remainder, lo shifts
//            dividend bits out and quotient bits in; opnd is the divisor.
//  Ports: is_div, hi, lo, opnd in; hi_n, lo_n out (next {hi,lo}).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        fits   = rem_sh >= {1'b0, opnd};
        // When the divisor fits, the true difference is < opnd, so the low
        // WIDTH bits hold it exactly.
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            hi_n = fits ? diff : rem_sh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], fits};
        end else begin
            // Carry of the add becomes the new top bit after the right shift.
            {hi_n, lo_n} = {sum, lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative execute-stage multiply/divide with HI/LO.
//  clk, rst_n  : clock, asynchronous active-low reset
//  bus (slave) : StartE/ALUControlE/SrcAE/SrcBE/FlushE in;
//                StallMD (stall F/D/E), DoneE (result pulse), HiE, LoE out
// Signed ops run on magnitudes; signs are reapplied in FIXUP. Divide by
// zero skips RUN and returns LO=all-ones, HI=dividend.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_muldiv_unit_if.slave  bus
);
    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_q, neg_r, dz;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo, hi_q, lo_q;
    logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
    logic             accept, op_div, op_signed, sgn_a, sgn_b, div_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_div    = (bus.ALUControlE == ALU_DIV) || (bus.ALUControlE == ALU_DIVU);
    assign op_signed = (bus.ALUControlE == ALU_DIV) || (bus.ALUControlE == ALU_MUL);
    assign sgn_a     = op_signed & bus.SrcAE[WIDTH-1];
    assign sgn_b     = op_signed & bus.SrcBE[WIDTH-1];
    // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
    assign abs_a     = sgn_a ? -bus.SrcAE : bus.SrcAE;
    assign abs_b     = sgn_b ? -bus.SrcBE : bus.SrcBE;
    assign div_zero  = op_div && (bus.SrcBE == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            MD_IDLE: begin
                accept = bus.StartE & is_md_op(bus.ALUControlE) & ~bus.FlushE;
                if (accept) state_n = div_zero ? MD_FIXUP : MD_RUN;
            end
            MD_RUN: begin
                if (bus.FlushE)                           state_n = MD_IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))        state_n = MD_FIXUP;
            end
            MD_FIXUP: state_n = bus.FlushE ? MD_IDLE : MD_DONE;
            MD_DONE:  state_n = MD_IDLE;
            default:  state_n = MD_IDLE;
        endcase
    end

    assign bus.StallMD = accept | (state == MD_RUN) | (state == MD_FIXUP);
    assign bus.DoneE   = (state == MD_DONE);
    assign bus.HiE     = hi_q;
    assign bus.LoE     = lo_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .opnd   (opnd),
        .hi_n   (step_hi),
        .lo_n   (step_lo)
    );

    always_comb begin
        {res_hi, res_lo} = {acc_hi, acc_lo};
        if (dz) begin
            {res_hi, res_lo} = {acc_hi, acc_lo};
        end else if (is_div) begin
            res_hi = neg_r ? -acc_hi : acc_hi;
            res_lo = neg_q ? -acc_lo : acc_lo;
        end else if (neg_q) begin
            {res_hi, res_lo} = -{acc_hi, acc_lo};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                is_div <= op_div;
                neg_q  <= sgn_a ^ sgn_b;
                neg_r  <= sgn_a;
                dz     <= div_zero;
                if (div_zero) begin
                    acc_hi <= bus.SrcAE;
                    acc_lo <= '1;
                end else if (op_div) begin
                    acc_hi <= '0;
                    acc_lo <= abs_a;
                    opnd   <= abs_b;
                end else begin
                    acc_hi <= '0;
                    acc_lo <= abs_b;
                    opnd   <= abs_a;
                end
            end else if (state == MD_RUN) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 1'b1;
            end
            if (state == MD_FIXUP && !bus.FlushE) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    import ex_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(W)) bus();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          done_cyc = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ALU_MULU: p = {32'b0, a} * {32'b0, b};
            ALU_MUL:  p = 64'(sa * sb);
            ALU_DIVU: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Monitor: every DoneE pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.DoneE) begin
            if (sb_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else                  chk("result", {bus.HiE, bus.LoE}, sb_q.pop_front());
        end
    end

    // Issue one op; checks StallMD every cycle and DoneE latency.
    // hold=1 keeps StartE high with junk while busy (must be ignored).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        int  exp_lat, lat;
        bit  stall_ok, got;
        exp_lat = ((op == ALU_DIV || op == ALU_DIVU) && b == 0) ? 2 : W + 2;
        @(negedge clk);
        bus.StartE = 1'b1; bus.ALUControlE = op; bus.SrcAE = a; bus.SrcBE = b;
        sb_q.push_back(model(op, a, b));
        last_exp = model(op, a, b);
        #1;
        stall_ok = (bus.StallMD === 1'b1);
        got = 1'b0; lat = -1;
        for (int k = 1; k <= W + 10 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    bus.ALUControlE = 5'($urandom_range(0, 31));
                    bus.SrcAE = $urandom; bus.SrcBE = $urandom;
                end else bus.StartE = 1'b0;
            end
            if (bus.StallMD !== (k < exp_lat)) stall_ok = 1'b0;
            if (bus.DoneE === 1'b1) begin
                got = 1'b1; lat = k; done_cyc = cyc; bus.StartE = 1'b0;
            end
        end
        bus.StartE = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("stall_profile", 64'(stall_ok), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ops[4];
        int d1;
        ops[0] = ALU_MUL; ops[1] = ALU_MULU; ops[2] = ALU_DIV; ops[3] = ALU_DIVU;
        rst_n = 1'b0;
        bus.StartE = 1'b0; bus.ALUControlE = '0; bus.SrcAE = '0; bus.SrcBE = '0; bus.FlushE = 1'b0;
        #1;
        chk("reset_state", {30'b0, bus.StallMD, bus.DoneE, bus.HiE, bus.LoE} , 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(ALU_MULU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        run_op(ALU_MUL,  32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(ALU_DIVU, 32'd100, 32'd0, 1'b0);
        run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(ALU_DIV,  32'h8000_0000, 32'd0, 1'b0);
        run_op(ALU_MUL,  32'h8000_0000, 32'h8000_0000, 1'b0);

        // Flush mid-divide: no DoneE, HI/LO keep the prior result.
        @(negedge clk);
        bus.StartE = 1'b1; bus.ALUControlE = ALU_DIVU; bus.SrcAE = 32'd1000; bus.SrcBE = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.StartE = 1'b0;
        end
        bus.FlushE = 1'b1;
        @(negedge clk);
        bus.FlushE = 1'b0;
        chk("flush_stall", 64'(bus.StallMD), 64'd0);
        chk("flush_hold", {bus.HiE, bus.LoE}, last_exp);
        repeat (W + 5) @(negedge clk);
        chk("flush_hold_late", {bus.HiE, bus.LoE}, last_exp);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.StartE = 1'b1; bus.ALUControlE = ALU_MUL; bus.SrcAE = 32'd123; bus.SrcBE = 32'd456;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) bus.StartE = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("async_reset", {30'b0, bus.StallMD, bus.DoneE, bus.HiE, bus.LoE}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(ALU_DIVU, 32'd9, 32'd4, 1'b0);

        // Non-muldiv op is not accepted.
        @(negedge clk);
        bus.StartE = 1'b1; bus.ALUControlE = ALU_ADD; bus.SrcAE = 32'd5; bus.SrcBE = 32'd6;
        #1;
        chk("add_no_stall", 64'(bus.StallMD), 64'd0);
        @(negedge clk);
        chk("add_idle", {62'b0, bus.StallMD, bus.DoneE}, 64'd0);
        bus.StartE = 1'b0;

        // Back-to-back: DoneE pulses W+3 cycles apart.
        run_op(ALU_MULU, 32'd3, 32'd5, 1'b0);
        d1 = done_cyc;
        run_op(ALU_MULU, 32'd6, 32'd7, 1'b0);
        chk("b2b_gap", 64'(done_cyc - d1), 64'(W + 3));

        // Randomized ops
        for (int i = 0; i < 24; i++)
            run_op(ops[$urandom_range(0, 3)], pick(), pick(), 1'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
